// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C master arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int OWNER_W  = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arbState_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Round-robin picker: first set req strictly after lastOwner, wrapping.
// Latency: combinational.
// Backpressure: none; pickVld low when no request is eligible.
// Ports: req (candidates), lastOwner (previous winner) -> pick (one-hot), pickIdx, pickVld.
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] lastOwner,
  output logic [NREQ-1:0]    pick,
  output logic [OWNER_W-1:0] pickIdx,
  output logic               pickVld
);

  // Two ascending scans: indices above lastOwner first, then the wrap-around
  // part up to and including lastOwner. Keeps every index a loop constant.
  always_comb begin
    pick    = '0;
    pickIdx = lastOwner;
    pickVld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pickVld && req[k] && (k > int'(lastOwner))) begin
        pick[k] = 1'b1;
        pickIdx = OWNER_W'(k);
        pickVld = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!pickVld && req[k] && (k <= int'(lastOwner))) begin
        pick[k] = 1'b1;
        pickIdx = OWNER_W'(k);
        pickVld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one byte-level I2C master between NREQ drivers, granting whole transactions round-robin.
// Latency: gnt one cycle after req (master idle), traffic one cycle later; release takes >= 2 cycles.
// Backpressure: requests wait in IDLE while the master is busy; non-owners see an idle, busy master.
// Ports: req/gnt per requester; rq_* requester-side master handshake; m_* shared master side;
//        busy (state != IDLE), owner (current/last owner), timeout_err (watchdog release pulse).
// Option: define ARB_TIMEOUT_EN to enable the stall watchdog (limit TIMEOUT_CYCLES).
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  input  logic [NREQ-1:0]     rq_start,
  input  logic [NREQ-1:0]     rq_send,
  input  logic [NREQ-1:0]     rq_receive,
  input  logic [8*NREQ-1:0]   rq_datasend,
  output logic [NREQ-1:0]     rq_isReady,
  output logic [NREQ-1:0]     rq_sended,
  output logic [NREQ-1:0]     rq_received,
  output logic [7:0]          rq_datareceive,
  input  logic                m_isReady,
  output logic                m_start,
  output logic                m_send,
  output logic                m_receive,
  output logic [7:0]          m_datasend,
  input  logic                m_sended,
  input  logic                m_received,
  input  logic [7:0]          m_datareceive,
  output logic                busy,
  output logic [OWNER_W-1:0]  owner,
  output logic                timeout_err
);

  if (NREQ < 1 || NREQ > MAX_NREQ || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadConfig
    $error("i2c_master_arbiter: NREQ or TIMEOUT_CYCLES out of range");
  end

  arbState_t          state;
  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    pick;
  logic [OWNER_W-1:0] pickIdx;
  logic               pickVld;
  logic               ownerReq;
  logic               wdFire;
  logic               ownActive;

  // gnt is one-hot on the owner while GRANT/OWN, so this is req[owner] there.
  assign ownerReq = |(req & gnt);

`ifdef ARB_TIMEOUT_EN
  logic [15:0]     wdCnt;
  logic            prevSended;
  logic            prevReceived;
  logic            progress;
  logic [NREQ-1:0] toMask;

  assign progress = (m_sended != prevSended) || (m_received != prevReceived);
  // Fires on the TIMEOUT_CYCLES-th stalled OWN cycle; a simultaneous req drop wins.
  assign wdFire   = (state == OWN) && ownerReq && !progress &&
                    (wdCnt == 16'(TIMEOUT_CYCLES - 1));
  assign eligible = req & ~toMask;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdCnt        <= '0;
      prevSended   <= 1'b0;
      prevReceived <= 1'b0;
      toMask       <= '0;
      timeout_err  <= 1'b0;
    end else begin
      prevSended   <= m_sended;
      prevReceived <= m_received;
      if (state != OWN || progress) wdCnt <= '0;
      else                          wdCnt <= wdCnt + 16'd1;
      // A timed-out requester stays masked until it lowers its req.
      toMask      <= (toMask | (wdFire ? gnt : '0)) & req;
      timeout_err <= wdFire;
    end
  end
`else
  assign wdFire      = 1'b0;
  assign eligible    = req;
  assign timeout_err = 1'b0;
`endif

  i2c_rr_pick #(.NREQ(NREQ)) picker (
    .req       (eligible),
    .lastOwner (owner),
    .pick      (pick),
    .pickIdx   (pickIdx),
    .pickVld   (pickVld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= OWNER_W'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (m_isReady && pickVld) begin
            owner <= pickIdx;
            gnt   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!ownerReq) begin
            gnt   <= '0;
            state <= RELEASE;
          end else begin
            state <= OWN;
          end
        end
        OWN: begin
          if (!ownerReq || wdFire) begin
            gnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (m_isReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Reset gates the routing directly so the master sees zeros in the reset cycle itself.
  assign ownActive      = (state == OWN) && !reset;
  assign rq_datareceive = m_datareceive;

  always_comb begin
    m_start     = 1'b0;
    m_send      = 1'b0;
    m_receive   = 1'b0;
    m_datasend  = 8'h00;
    rq_isReady  = '0;
    rq_sended   = '0;
    rq_received = '0;
    if (ownActive) begin
      for (int k = 0; k < NREQ; k++) begin
        if (int'(owner) == k) begin
          m_start        = rq_start[k];
          m_send         = rq_send[k];
          m_receive      = rq_receive[k];
          m_datasend     = rq_datasend[8*k +: 8];
          rq_isReady[k]  = m_isReady;
          rq_sended[k]   = m_sended;
          rq_received[k] = m_received;
        end
      end
    end
  end

endmodule
